// File: rtl/control_fsm.sv
// Multi-cycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, opcode
// decode to datapath controls, memory-wait timeout to a sticky ERROR state.
module control_fsm #(
  parameter int unsigned OPW     = 5,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  input  logic           n_flag,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_sel,
  output logic           ir_load,
  output logic           pc_enable,
  output logic [1:0]     PCSrc,
  output logic           RegWrite,
  output logic           MemWrite,
  output logic           ALUOp,
  output logic           ALUSrc,
  output logic           RegDst,
  output logic           ExtSel,
  output logic           NZ,
  output logic [2:0]     WBSrc,
  output logic [2:0]     state,
  output logic           err,
  output logic           illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_mem;
    logic       is_st;
    logic       alu_op;
    logic       alu_src;
    logic       ext_sel;
    logic       nz;
    logic       reg_write;
    logic       reg_dst;
    logic [2:0] wb_src;
    logic [1:0] pc_src;
  } dec_t;

  // Register forms live at 00xxx/01xxx, immediate and branch forms at 1xxxx.
  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_CMP   = 5'b00011;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_ST    = 5'b00101;
  localparam logic [4:0] OP_JR    = 5'b01000;
  localparam logic [4:0] OP_JZR   = 5'b01001;
  localparam logic [4:0] OP_JNR   = 5'b01010;
  localparam logic [4:0] OP_CALLR = 5'b01100;
  localparam logic [4:0] OP_MVI   = 5'b10000;
  localparam logic [4:0] OP_ADDI  = 5'b10001;
  localparam logic [4:0] OP_SUBI  = 5'b10010;
  localparam logic [4:0] OP_CMPI  = 5'b10011;
  localparam logic [4:0] OP_MVHI  = 5'b10110;
  localparam logic [4:0] OP_J     = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;
  localparam logic [4:0] OP_CALL  = 5'b11100;

  localparam logic [CW-1:0] TO_CW = CW'(TIMEOUT);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [CW-1:0]  wait_cnt, wait_inc;
  logic           timeout_hit;
  dec_t           dec;

  assign wait_inc    = wait_cnt + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && !mem_ready && (wait_inc == TO_CW);
  assign state       = state_q;
  assign err         = (state_q == S_ERROR);

  always_comb begin
    dec        = '0;
    dec.legal  = 1'b1;
    dec.wb_src = 3'b001;
    dec.pc_src = 2'b10;
    if ((op_q >> 5) != '0) begin
      dec.legal = 1'b0;
    end else begin
      case (op_q[4:0])
        OP_MV:    begin dec.reg_write = 1'b1; dec.wb_src = 3'b011; end
        OP_ADD:   dec.reg_write = 1'b1;
        OP_SUB:   begin dec.reg_write = 1'b1; dec.alu_op = 1'b1; end
        OP_CMP:   begin dec.alu_op = 1'b1; dec.nz = 1'b1; end
        OP_LD:    begin dec.is_mem = 1'b1; dec.reg_write = 1'b1; dec.wb_src = 3'b000; end
        OP_ST:    begin dec.is_mem = 1'b1; dec.is_st = 1'b1; end
        OP_MVI:   begin dec.reg_write = 1'b1; dec.wb_src = 3'b100; end
        OP_ADDI:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.nz = 1'b1; end
        OP_SUBI:  begin
          dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 1'b1; dec.nz = 1'b1;
        end
        OP_CMPI:  begin dec.alu_src = 1'b1; dec.alu_op = 1'b1; dec.nz = 1'b1; end
        OP_MVHI:  begin dec.reg_write = 1'b1; dec.wb_src = 3'b100; end
        OP_J:     begin dec.ext_sel = 1'b1; dec.pc_src = 2'b00; end
        OP_JZ:    begin dec.ext_sel = 1'b1; dec.pc_src = z_flag ? 2'b00 : 2'b10; end
        OP_JN:    begin dec.ext_sel = 1'b1; dec.pc_src = n_flag ? 2'b00 : 2'b10; end
        OP_CALL:  begin
          dec.ext_sel = 1'b1; dec.reg_write = 1'b1; dec.reg_dst = 1'b1;
          dec.wb_src  = 3'b010; dec.pc_src = 2'b00;
        end
        OP_JR:    dec.pc_src = 2'b01;
        OP_JZR:   dec.pc_src = z_flag ? 2'b01 : 2'b10;
        OP_JNR:   dec.pc_src = n_flag ? 2'b01 : 2'b10;
        OP_CALLR: begin
          dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.wb_src = 3'b010; dec.pc_src = 2'b01;
        end
        default:  dec.legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    ir_load   = 1'b0;
    pc_enable = 1'b0;
    PCSrc     = 2'b10;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUOp     = 1'b0;
    ALUSrc    = 1'b0;
    RegDst    = 1'b0;
    ExtSel    = 1'b0;
    NZ        = 1'b0;
    WBSrc     = 3'b001;
    illegal   = 1'b0;
    // Strobes stay quiet while reset is held so nothing reaches memory before the first fetch.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_ERROR;
          end
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          ALUOp   = dec.alu_op;
          ALUSrc  = dec.alu_src;
          ExtSel  = dec.ext_sel;
          NZ      = dec.nz;
          illegal = !dec.legal;
          state_d = dec.is_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_sel  = 1'b1;
          MemWrite = dec.is_st;
          if (mem_ready) begin
            if (dec.is_st) begin
              pc_enable = 1'b1;
              state_d   = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (timeout_hit) begin
            state_d = S_ERROR;
          end
        end
        S_WB: begin
          pc_enable = 1'b1;
          PCSrc     = dec.pc_src;
          RegWrite  = dec.reg_write;
          RegDst    = dec.reg_dst;
          WBSrc     = dec.wb_src;
          state_d   = S_FETCH;
        end
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (mem_ready || (state_d != state_q)) begin
        wait_cnt <= '0;
      end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
        wait_cnt <= wait_inc;
      end
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: default instance plus an OPW=6 instance in lockstep
// to exercise the upper-opcode-bit illegal check.
module tb_control_fsm;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_sel;
    logic       ir_load;
    logic       pc_enable;
    logic [1:0] pcsrc;
    logic       reg_write;
    logic       mem_write;
    logic       alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       ext_sel;
    logic       nz;
    logic [2:0] wbsrc;
    logic       err;
    logic       illegal;
  } out_t;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_ERROR = 3'd7;

  logic       clk, reset, z_flag, n_flag, mem_ready, hi6;
  logic [4:0] opcode;
  logic [5:0] opcode6;
  assign opcode6 = {hi6, opcode};

  logic       a_mem_req, a_mem_sel, a_ir_load, a_pc_enable, a_RegWrite, a_MemWrite;
  logic       a_ALUOp, a_ALUSrc, a_RegDst, a_ExtSel, a_NZ, a_err, a_illegal;
  logic [1:0] a_PCSrc;
  logic [2:0] a_WBSrc, a_state;
  logic       b_mem_req, b_mem_sel, b_ir_load, b_pc_enable, b_RegWrite, b_MemWrite;
  logic       b_ALUOp, b_ALUSrc, b_RegDst, b_ExtSel, b_NZ, b_err, b_illegal;
  logic [1:0] b_PCSrc;
  logic [2:0] b_WBSrc, b_state;
  out_t       o1, o2;

  assign o1 = {a_state, a_mem_req, a_mem_sel, a_ir_load, a_pc_enable, a_PCSrc, a_RegWrite,
               a_MemWrite, a_ALUOp, a_ALUSrc, a_RegDst, a_ExtSel, a_NZ, a_WBSrc, a_err, a_illegal};
  assign o2 = {b_state, b_mem_req, b_mem_sel, b_ir_load, b_pc_enable, b_PCSrc, b_RegWrite,
               b_MemWrite, b_ALUOp, b_ALUSrc, b_RegDst, b_ExtSel, b_NZ, b_WBSrc, b_err, b_illegal};

  control_fsm u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z_flag(z_flag), .n_flag(n_flag),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_sel(a_mem_sel), .ir_load(a_ir_load),
    .pc_enable(a_pc_enable), .PCSrc(a_PCSrc), .RegWrite(a_RegWrite), .MemWrite(a_MemWrite),
    .ALUOp(a_ALUOp), .ALUSrc(a_ALUSrc), .RegDst(a_RegDst), .ExtSel(a_ExtSel), .NZ(a_NZ),
    .WBSrc(a_WBSrc), .state(a_state), .err(a_err), .illegal(a_illegal)
  );

  control_fsm #(.OPW(6)) u_dut6 (
    .clk(clk), .reset(reset), .opcode(opcode6), .z_flag(z_flag), .n_flag(n_flag),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_sel(b_mem_sel), .ir_load(b_ir_load),
    .pc_enable(b_pc_enable), .PCSrc(b_PCSrc), .RegWrite(b_RegWrite), .MemWrite(b_MemWrite),
    .ALUOp(b_ALUOp), .ALUSrc(b_ALUSrc), .RegDst(b_RegDst), .ExtSel(b_ExtSel), .NZ(b_NZ),
    .WBSrc(b_WBSrc), .state(b_state), .err(b_err), .illegal(b_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic out_t idle(input logic [2:0] st);
    out_t r;
    r       = '0;
    r.state = st;
    r.pcsrc = 2'b10;
    r.wbsrc = 3'b001;
    return r;
  endfunction

  task automatic check(input string tag, input out_t got, input out_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h (state %0d) expected %h (state %0d)",
             tag, got, got.state, exp, exp.state);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects mem_ready=1 and opcode already set; leaves the DUT in EXEC.
  task automatic fetch_decode(input string tag);
    out_t e;
    e = idle(ST_FETCH); e.mem_req = 1'b1; e.ir_load = 1'b1;
    check({tag, "_fetch"}, o1, e);
    tick();
    check({tag, "_decode"}, o1, idle(ST_DECODE));
    tick();
  endtask

  out_t e;

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 5'b00000; hi6 = 1'b0;
    z_flag = 1'b0; n_flag = 1'b0;
    tick(); tick();
    check("reset_hold", o1, idle(ST_FETCH));
    check("reset_hold6", o2, idle(ST_FETCH));

    // add with zero wait, two back-to-back instructions
    reset = 1'b0; mem_ready = 1'b1; opcode = 5'b00001; #1;
    for (int k = 0; k < 2; k++) begin
      fetch_decode("add");
      check("add_exec", o1, idle(ST_EXEC));
      tick();
      e = idle(ST_WB); e.pc_enable = 1'b1; e.reg_write = 1'b1;
      check("add_wb", o1, e);
      tick();
    end

    // jz taken then not taken; flags sampled in WB
    opcode = 5'b11001;
    for (int k = 0; k < 2; k++) begin
      fetch_decode("jz");
      e = idle(ST_EXEC); e.ext_sel = 1'b1;
      check("jz_exec", o1, e);
      tick();
      z_flag = (k == 0); #1;
      e = idle(ST_WB); e.pc_enable = 1'b1; e.pcsrc = (k == 0) ? 2'b00 : 2'b10;
      check(k == 0 ? "jz_taken_wb" : "jz_not_taken_wb", o1, e);
      tick();
    end
    z_flag = 1'b0;

    // addi: immediate ALU source, flag update, ALU writeback
    opcode = 5'b10001;
    fetch_decode("addi");
    e = idle(ST_EXEC); e.alu_src = 1'b1; e.nz = 1'b1;
    check("addi_exec", o1, e);
    tick();
    e = idle(ST_WB); e.pc_enable = 1'b1; e.reg_write = 1'b1;
    check("addi_wb", o1, e);
    tick();

    // cmp: subtract with flags, no register write
    opcode = 5'b00011;
    fetch_decode("cmp");
    e = idle(ST_EXEC); e.alu_op = 1'b1; e.nz = 1'b1;
    check("cmp_exec", o1, e);
    tick();
    e = idle(ST_WB); e.pc_enable = 1'b1;
    check("cmp_wb", o1, e);
    tick();

    // call: imm11 target, link to R7 with pc+2
    opcode = 5'b11100;
    fetch_decode("call");
    e = idle(ST_EXEC); e.ext_sel = 1'b1;
    check("call_exec", o1, e);
    tick();
    e = idle(ST_WB); e.pc_enable = 1'b1; e.reg_write = 1'b1; e.reg_dst = 1'b1;
    e.wbsrc = 3'b010; e.pcsrc = 2'b00;
    check("call_wb", o1, e);
    tick();

    // jnr with n_flag set selects register target
    opcode = 5'b01010;
    fetch_decode("jnr");
    check("jnr_exec", o1, idle(ST_EXEC));
    tick();
    n_flag = 1'b1; #1;
    e = idle(ST_WB); e.pc_enable = 1'b1; e.pcsrc = 2'b01;
    check("jnr_wb", o1, e);
    tick();
    n_flag = 1'b0;

    // ld with three wait cycles in MEM
    opcode = 5'b00100;
    fetch_decode("ld");
    check("ld_exec", o1, idle(ST_EXEC));
    tick();
    mem_ready = 1'b0; #1;
    e = idle(ST_MEM); e.mem_req = 1'b1; e.mem_sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("ld_mem_wait", o1, e);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("ld_mem_ready", o1, e);
    tick();
    e = idle(ST_WB); e.pc_enable = 1'b1; e.reg_write = 1'b1; e.wbsrc = 3'b000;
    check("ld_wb", o1, e);
    tick();

    // st with zero wait retires from MEM
    opcode = 5'b00101;
    fetch_decode("st");
    check("st_exec", o1, idle(ST_EXEC));
    tick();
    e = idle(ST_MEM); e.mem_req = 1'b1; e.mem_sel = 1'b1; e.mem_write = 1'b1; e.pc_enable = 1'b1;
    check("st_mem", o1, e);
    tick();
    e = idle(ST_FETCH); e.mem_req = 1'b1; e.ir_load = 1'b1;
    check("st_back_to_fetch", o1, e);

    // illegal 00111 on both instances
    opcode = 5'b00111; #1;
    fetch_decode("ill");
    e = idle(ST_EXEC); e.illegal = 1'b1;
    check("ill_exec", o1, e);
    check("ill_exec6", o2, e);
    tick();
    e = idle(ST_WB); e.pc_enable = 1'b1;
    check("ill_wb", o1, e);
    check("ill_wb6", o2, e);
    tick();

    // upper opcode bit set: 100001 illegal on OPW=6 while plain add runs on OPW=5
    opcode = 5'b00001; hi6 = 1'b1; #1;
    fetch_decode("hi");
    check("hi_exec_add", o1, idle(ST_EXEC));
    e = idle(ST_EXEC); e.illegal = 1'b1;
    check("hi_exec6", o2, e);
    tick();
    e = idle(ST_WB); e.pc_enable = 1'b1; e.reg_write = 1'b1;
    check("hi_wb_add", o1, e);
    e = idle(ST_WB); e.pc_enable = 1'b1;
    check("hi_wb6", o2, e);
    tick();
    hi6 = 1'b0;

    // fetch timeout: 15 wait cycles then sticky ERROR
    reset = 1'b1; tick();
    reset = 1'b0; mem_ready = 1'b0; #1;
    e = idle(ST_FETCH); e.mem_req = 1'b1;
    for (int k = 0; k < 15; k++) begin
      check("to_fetch_wait", o1, e);
      tick();
    end
    e = idle(ST_ERROR); e.err = 1'b1;
    check("to_error", o1, e);
    mem_ready = 1'b1;
    tick();
    check("to_error_sticky", o1, e);
    tick();
    check("to_error_sticky6", o2, e);
    reset = 1'b1; tick();
    check("to_reset_clears", o1, idle(ST_FETCH));

    // reset during MEM of st
    reset = 1'b0; opcode = 5'b00101; #1;
    fetch_decode("strst");
    check("strst_exec", o1, idle(ST_EXEC));
    tick();
    mem_ready = 1'b0; #1;
    e = idle(ST_MEM); e.mem_req = 1'b1; e.mem_sel = 1'b1; e.mem_write = 1'b1;
    check("strst_mem", o1, e);
    reset = 1'b1; #1;
    check("strst_mem_in_reset", o1, idle(ST_MEM));
    tick();
    check("strst_after_reset", o1, idle(ST_FETCH));
    reset = 1'b0; mem_ready = 1'b1; #1;
    e = idle(ST_FETCH); e.mem_req = 1'b1; e.ir_load = 1'b1;
    check("strst_first_fetch", o1, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
